// File: rtl/y_ctrl_main_decode.sv
// rtl/y_ctrl_main_decode.sv - single-cycle MIPS main control decoder with sticky illegal-opcode flag
// Optional addi support: define Y_CTRL_ADDI_EN.
module y_ctrl_main_decode #(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [OPW-1:0] opCode,
    output logic           rtype,
    output logic           lw,
    output logic           sw,
    output logic           jump,
    output logic           branch,
    output logic           RegDst,
    output logic           ALUSrc,
    output logic           RegWrite,
    output logic           Mem2Reg,
    output logic           MemRead,
    output logic           MemWrite,
    output logic [1:0]     ALUop,
    output logic           illegal,
    output logic           illegal_seen
);

    localparam logic [OPW-1:0] OP_RTYPE  = 6'b000000;
    localparam logic [OPW-1:0] OP_LW     = 6'b100011;
    localparam logic [OPW-1:0] OP_SW     = 6'b101011;
    localparam logic [OPW-1:0] OP_JUMP   = 6'b000010;
    localparam logic [OPW-1:0] OP_BRANCH = 6'b000100;
`ifdef Y_CTRL_ADDI_EN
    localparam logic [OPW-1:0] OP_ADDI   = 6'b001000;
`endif

    logic w_rtype;
    logic w_lw;
    logic w_sw;
    logic w_jump;
    logic w_branch;
    logic w_addi;
    logic w_illegal;
    logic r_illegal_seen;

    // Any opcode not listed, including one carrying X/Z in simulation, falls to default.
    always_comb begin
        w_rtype   = 1'b0;
        w_lw      = 1'b0;
        w_sw      = 1'b0;
        w_jump    = 1'b0;
        w_branch  = 1'b0;
        w_addi    = 1'b0;
        w_illegal = 1'b0;
        case (opCode)
            OP_RTYPE:  w_rtype  = 1'b1;
            OP_LW:     w_lw     = 1'b1;
            OP_SW:     w_sw     = 1'b1;
            OP_JUMP:   w_jump   = 1'b1;
            OP_BRANCH: w_branch = 1'b1;
`ifdef Y_CTRL_ADDI_EN
            OP_ADDI:   w_addi   = 1'b1;
`endif
            default:   w_illegal = 1'b1;
        endcase
    end

    assign rtype   = w_rtype;
    assign lw      = w_lw;
    assign sw      = w_sw;
    assign jump    = w_jump;
    assign branch  = w_branch;
    assign illegal = w_illegal;

    assign RegDst  = w_rtype;
    assign ALUSrc  = w_lw | w_sw | w_addi;
    assign Mem2Reg = w_lw;
    assign ALUop   = {w_rtype, w_branch};

    // State-changing enables are suppressed while reset is held.
    assign RegWrite = (w_rtype | w_lw | w_addi) & ~rst;
    assign MemRead  = w_lw & ~rst;
    assign MemWrite = w_sw & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_seen <= 1'b0;
        end else if (in_valid && w_illegal) begin
            r_illegal_seen <= 1'b1;
        end
    end

    assign illegal_seen = r_illegal_seen;

endmodule

// File: tb/tb_y_ctrl_main_decode.sv
// tb/tb_y_ctrl_main_decode.sv - self-checking bench for y_ctrl_main_decode
module tb_y_ctrl_main_decode;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [5:0] opCode;
    logic       rtype, lw, sw, jump, branch;
    logic       RegDst, ALUSrc, RegWrite, Mem2Reg, MemRead, MemWrite;
    logic [1:0] ALUop;
    logic       illegal, illegal_seen;

    int errors = 0;
    int checks = 0;

    y_ctrl_main_decode #(.OPW(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opCode(opCode),
        .rtype(rtype), .lw(lw), .sw(sw), .jump(jump), .branch(branch),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Mem2Reg(Mem2Reg),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUop(ALUop),
        .illegal(illegal), .illegal_seen(illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed order: rtype lw sw jump branch RegDst ALUSrc RegWrite Mem2Reg MemRead MemWrite ALUop[1:0] illegal
    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [13:0] outs();
        return {rtype, lw, sw, jump, branch, RegDst, ALUSrc, RegWrite,
                Mem2Reg, MemRead, MemWrite, ALUop, illegal};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [5:0] op);
        @(negedge clk);
        rst = r; in_valid = v; opCode = op;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; opCode = 6'b000000;

        vecs.push_back('{"rtype",      1'b0, 6'b000000, 14'b1_0_0_0_0_1_0_1_0_0_0_10_0});
        vecs.push_back('{"lw",         1'b0, 6'b100011, 14'b0_1_0_0_0_0_1_1_1_1_0_00_0});
        vecs.push_back('{"sw",         1'b0, 6'b101011, 14'b0_0_1_0_0_0_1_0_0_0_1_00_0});
        vecs.push_back('{"jump",       1'b0, 6'b000010, 14'b0_0_0_1_0_0_0_0_0_0_0_00_0});
        vecs.push_back('{"beq",        1'b0, 6'b000100, 14'b0_0_0_0_1_0_0_0_0_0_0_01_0});
        vecs.push_back('{"ill_3f",     1'b0, 6'b111111, 14'b0_0_0_0_0_0_0_0_0_0_0_00_1});
        vecs.push_back('{"ill_01",     1'b0, 6'b000001, 14'b0_0_0_0_0_0_0_0_0_0_0_00_1});
        vecs.push_back('{"ill_lb",     1'b0, 6'b100000, 14'b0_0_0_0_0_0_0_0_0_0_0_00_1});
`ifdef Y_CTRL_ADDI_EN
        vecs.push_back('{"addi",       1'b0, 6'b001000, 14'b0_0_0_0_0_0_1_1_0_0_0_00_0});
        vecs.push_back('{"addi_rst",   1'b1, 6'b001000, 14'b0_0_0_0_0_0_1_0_0_0_0_00_0});
`else
        vecs.push_back('{"addi_ill",   1'b0, 6'b001000, 14'b0_0_0_0_0_0_0_0_0_0_0_00_1});
`endif
        vecs.push_back('{"lw_rst",     1'b1, 6'b100011, 14'b0_1_0_0_0_0_1_0_1_0_0_00_0});
        vecs.push_back('{"sw_rst",     1'b1, 6'b101011, 14'b0_0_1_0_0_0_1_0_0_0_0_00_0});
        vecs.push_back('{"rtype_rst",  1'b1, 6'b000000, 14'b1_0_0_0_0_1_0_0_0_0_0_10_0});
        vecs.push_back('{"beq_rst",    1'b1, 6'b000100, 14'b0_0_0_0_1_0_0_0_0_0_0_01_0});

        // Reset state of the sticky flag.
        cyc(1'b1, 1'b0, 6'b000000);
        chk("seen_reset", {15'd0, illegal_seen}, 16'd0);

        // Combinational table, in_valid low so the flag must not move.
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; in_valid = 1'b0; opCode = vecs[i].op;
            #1;
            chk(vecs[i].name, {2'b00, outs()}, {2'b00, vecs[i].exp});
        end
        @(posedge clk);
        @(negedge clk);
        chk("seen_after_table", {15'd0, illegal_seen}, 16'd0);

        // Illegal opcode without in_valid is ignored.
        cyc(1'b0, 1'b0, 6'b111111);
        chk("seen_unqualified", {15'd0, illegal_seen}, 16'd0);

        // Qualified illegal opcode sets the flag one cycle later.
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; opCode = 6'b111111;
        #1;
        chk("seen_before_edge", {15'd0, illegal_seen}, 16'd0);
        @(posedge clk);
        @(negedge clk);
        chk("seen_set", {15'd0, illegal_seen}, 16'd1);

        // Sticky through legal traffic.
        cyc(1'b0, 1'b1, 6'b100011);
        cyc(1'b0, 1'b1, 6'b000000);
        cyc(1'b0, 1'b1, 6'b000100);
        chk("seen_sticky", {15'd0, illegal_seen}, 16'd1);

        // Cleared only by reset.
        cyc(1'b1, 1'b1, 6'b000000);
        chk("seen_cleared", {15'd0, illegal_seen}, 16'd0);

        // Reset wins over a simultaneous qualified illegal opcode.
        cyc(1'b1, 1'b1, 6'b111111);
        chk("seen_rst_wins", {15'd0, illegal_seen}, 16'd0);

        // Addi as a qualified opcode: sets the flag only when unsupported.
        cyc(1'b0, 1'b1, 6'b001000);
`ifdef Y_CTRL_ADDI_EN
        chk("seen_addi", {15'd0, illegal_seen}, 16'd0);
`else
        chk("seen_addi", {15'd0, illegal_seen}, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
